tcdm_burst_sequencer: RTL and testbench

Next-generation TCDM burst unit, placed between the tile crossbar and the bank ports. It detects burst requests on any of NrInOut ports and queues them in a configurable-depth FIFO. Each burst is expanded into single-word bank requests that may exceed the port count: elements wrap around modulo NrInOut and are issued over several beats. Each lane handshakes independently, so a slow bank stalls only its own lane. Non-burst traffic on lanes the current beat does not use passes through with zero latency.

---
 rtl/tcdm_burst_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tcdm_burst_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_burst_sequencer.sv
// TCDM burst sequencer: sits between the tile crossbar and the bank ports.
// Burst requests are arbitrated into a small fall-through queue and expanded
// into single-word bank requests spread over the lanes, one beat at a time.
// Non-burst traffic on lanes the current beat does not touch passes straight through.

package tcdm_burst_sequencer_pkg;
    typedef struct packed {
        logic       isburst;
        logic [4:0] blen;
    } burst_t;

    typedef struct packed {
        logic [0:0]  meta_id;
        logic [31:0] data;
    } wdata_t;

    typedef struct packed {
        burst_t     burst;
        wdata_t     wdata;
        logic [0:0] tgt_addr;
    } req_default_t;
endpackage

module tcdm_burst_sequencer #(
    parameter int unsigned NrInOut       = 4,
    parameter int unsigned FifoDepth     = 4,
    parameter int unsigned MaxBlen       = 16,
    parameter int unsigned MetaIdWidth   = 1,
    parameter int unsigned TCDMAddrWidth = 1,
    parameter type req_payload_t = tcdm_burst_sequencer_pkg::req_default_t,
    parameter type rsp_payload_t = logic,
    parameter type addr_t        = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  req_payload_t               req_payload_i [NrInOut],
    input  addr_t                      req_addr_i    [NrInOut],
    input  logic [NrInOut-1:0]         req_wide_i,
    input  logic [NrInOut-1:0]         req_valid_i,
    output logic [NrInOut-1:0]         req_ready_o,
    output req_payload_t               req_payload_o [NrInOut],
    output addr_t                      req_addr_o    [NrInOut],
    output logic [NrInOut-1:0]         req_wide_o,
    output logic [NrInOut-1:0]         req_valid_o,
    input  logic [NrInOut-1:0]         req_ready_i,
    input  rsp_payload_t               rsp_payload_i [NrInOut],
    input  addr_t                      rsp_addr_i    [NrInOut],
    input  logic [NrInOut-1:0]         rsp_wide_i,
    input  logic [NrInOut-1:0]         rsp_valid_i,
    output logic [NrInOut-1:0]         rsp_ready_o,
    output rsp_payload_t               rsp_payload_o [NrInOut],
    output addr_t                      rsp_addr_o    [NrInOut],
    output logic [NrInOut-1:0]         rsp_wide_o,
    output logic [NrInOut-1:0]         rsp_valid_o,
    input  logic [NrInOut-1:0]         rsp_ready_i,
    output logic                       busy_o,
    output logic [$clog2(FifoDepth):0] fifo_usage_o
);

    localparam int          N     = int'(NrInOut);
    localparam int unsigned BlenW = $clog2(MaxBlen + 1);
    localparam int unsigned IdxW  = (NrInOut > 1) ? $clog2(NrInOut) : 1;
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW  = $clog2(FifoDepth) + 1;
    localparam int unsigned Slots = 1 << PtrW;

    typedef enum logic {Idle, Issue} state_e;

    state_e              state_reg;
    logic [BlenW-1:0]    beat_reg;
    logic [NrInOut-1:0]  issued_reg;
    req_payload_t        cur_payload_reg;
    addr_t               cur_addr_reg;
    logic                cur_wide_reg;
    logic [IdxW-1:0]     cur_idx_reg;
    logic [BlenW-1:0]    cur_blen_reg;

    logic [IdxW-1:0]     rr_ptr_reg;
    logic                lock_reg;
    logic [IdxW-1:0]     lock_idx_reg;

    req_payload_t        fifo_payload_q [Slots];
    addr_t               fifo_addr_q    [Slots];
    logic                fifo_wide_q    [Slots];
    logic [IdxW-1:0]     fifo_idx_q     [Slots];
    logic [PtrW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]     count_reg;

    logic [NrInOut-1:0]  burst_req;
    logic                win_valid;
    logic [IdxW-1:0]     win_idx;
    logic                fifo_empty, fifo_full, pop_stored, push, pop, write_fifo;
    req_payload_t        head_payload;
    addr_t               head_addr;
    logic                head_wide;
    logic [IdxW-1:0]     head_idx;
    logic [NrInOut-1:0]  lane_active, lane_issue, lane_pending;
    logic                beat_done, last_beat;

    // Round-robin pick among burst-requesting lanes; held on the same lane while it waits
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (lock_reg) begin
            win_valid = burst_req[lock_idx_reg];
            win_idx   = lock_idx_reg;
        end else begin
            for (int o = 0; o < N; o++) begin
                if (!win_valid && burst_req[(int'(rr_ptr_reg) + o) % N]) begin
                    win_valid = 1'b1;
                    win_idx   = IdxW'((int'(rr_ptr_reg) + o) % N);
                end
            end
        end
    end

    // Queue control: an empty queue in Idle hands the incoming burst straight to the FSM
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CntW'(FifoDepth));
    assign pop_stored = (state_reg == Idle) && !fifo_empty;
    assign push       = win_valid && (!fifo_full || pop_stored);
    assign pop        = (state_reg == Idle) && (!fifo_empty || push);
    assign write_fifo = push && !(fifo_empty && (state_reg == Idle));

    assign head_payload = fifo_empty ? req_payload_i[win_idx] : fifo_payload_q[rd_ptr_reg];
    assign head_addr    = fifo_empty ? req_addr_i[win_idx]    : fifo_addr_q[rd_ptr_reg];
    assign head_wide    = fifo_empty ? req_wide_i[win_idx]    : fifo_wide_q[rd_ptr_reg];
    assign head_idx     = fifo_empty ? win_idx                : fifo_idx_q[rd_ptr_reg];

    // Queue storage is written only; no reset needed on the data
    always_ff @(posedge clk_i) begin
        if (write_fifo) begin
            fifo_payload_q[wr_ptr_reg] <= req_payload_i[win_idx];
            fifo_addr_q[wr_ptr_reg]    <= req_addr_i[win_idx];
            fifo_wide_q[wr_ptr_reg]    <= req_wide_i[win_idx];
            fifo_idx_q[wr_ptr_reg]     <= win_idx;
        end
    end

    // Queue pointers, occupancy and arbiter rotation/lock state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            if (write_fifo) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_stored) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CntW'(write_fifo) - CntW'(pop_stored);
            if (push) begin
                lock_reg   <= 1'b0;
                rr_ptr_reg <= (win_idx == IdxW'(N - 1)) ? '0 : win_idx + 1'b1;
            end else if (win_valid) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= win_idx;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_lane
        int           elem;
        req_payload_t bank_payload;

        assign burst_req[gi] = req_valid_i[gi] & req_payload_i[gi].burst.isburst;
        // Element index this lane carries in the current beat
        assign elem = int'(beat_reg) * N + ((gi + N - int'(cur_idx_reg)) % N);
        assign lane_active[gi]  = (state_reg == Issue) && (elem < int'(cur_blen_reg));
        assign lane_issue[gi]   = lane_active[gi] && !issued_reg[gi]
                                  && !(rsp_valid_i[gi] && !rsp_ready_i[gi]);
        assign lane_pending[gi] = lane_active[gi] && !issued_reg[gi]
                                  && !(lane_issue[gi] && req_ready_i[gi]);

        // Single-word bank request derived from the latched burst
        always_comb begin
            bank_payload                = cur_payload_reg;
            bank_payload.burst.isburst  = 1'b0;
            bank_payload.burst.blen     = '0;
            bank_payload.wdata.meta_id  = cur_payload_reg.wdata.meta_id + MetaIdWidth'(elem);
            bank_payload.tgt_addr       = cur_payload_reg.tgt_addr + TCDMAddrWidth'(elem);
        end

        assign req_payload_o[gi] = lane_active[gi] ? bank_payload : req_payload_i[gi];
        assign req_addr_o[gi]    = lane_active[gi] ? cur_addr_reg : req_addr_i[gi];
        assign req_wide_o[gi]    = lane_active[gi] ? cur_wide_reg : req_wide_i[gi];
        assign req_valid_o[gi]   = lane_active[gi] ? lane_issue[gi]
                                                   : (req_valid_i[gi] && !burst_req[gi]);
        assign req_ready_o[gi]   = burst_req[gi] ? (push && (win_idx == IdxW'(gi)))
                                                 : (!lane_active[gi] && req_ready_i[gi]);

        assign rsp_payload_o[gi] = rsp_payload_i[gi];
        assign rsp_addr_o[gi]    = rsp_addr_i[gi];
        assign rsp_wide_o[gi]    = rsp_wide_i[gi];
        assign rsp_valid_o[gi]   = rsp_valid_i[gi];
        assign rsp_ready_o[gi]   = rsp_ready_i[gi];
    end

    assign beat_done = (lane_pending == '0);
    assign last_beat = ((int'(beat_reg) + 1) * N) >= int'(cur_blen_reg);

    // Sequencer FSM: latch a burst in Idle, walk its beats in Issue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= Idle;
            beat_reg        <= '0;
            issued_reg      <= '0;
            cur_payload_reg <= '0;
            cur_addr_reg    <= '0;
            cur_wide_reg    <= 1'b0;
            cur_idx_reg     <= '0;
            cur_blen_reg    <= '0;
        end else begin
            case (state_reg)
                Idle: begin
                    if (pop) begin
                        cur_payload_reg <= head_payload;
                        cur_addr_reg    <= head_addr;
                        cur_wide_reg    <= head_wide;
                        cur_idx_reg     <= head_idx;
                        cur_blen_reg    <= head_payload.burst.blen;
                        beat_reg        <= '0;
                        issued_reg      <= '0;
                        if (head_payload.burst.blen != '0) begin
                            state_reg <= Issue;
                        end
                    end
                end
                Issue: begin
                    if (beat_done) begin
                        issued_reg <= '0;
                        if (last_beat) begin
                            state_reg <= Idle;
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                        end
                    end else begin
                        issued_reg <= issued_reg | (lane_issue & req_ready_i);
                    end
                end
                default: state_reg <= Idle;
            endcase
        end
    end

    assign busy_o       = (state_reg != Idle) || !fifo_empty;
    assign fifo_usage_o = count_reg;

    a_nr_lanes:  assert property (@(posedge clk_i) NrInOut >= 1);
    a_fifo_size: assert property (@(posedge clk_i) FifoDepth >= 1);
    a_blen_max:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  push |-> (int'(req_payload_i[win_idx].burst.blen) <= int'(MaxBlen)));

endmodule

// File: tb/tb_tcdm_burst_sequencer.sv
// Directed bench for tcdm_burst_sequencer with 4 lanes and a single-entry burst queue.
module tb_tcdm_burst_sequencer;

    localparam int N = 4;

    typedef struct packed {
        logic       isburst;
        logic [4:0] blen;
    } burst_t;

    typedef struct packed {
        logic [3:0]  meta_id;
        logic [15:0] data;
    } wdata_t;

    typedef struct packed {
        burst_t     burst;
        wdata_t     wdata;
        logic [7:0] tgt_addr;
    } req_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    req_t        req_payload_i [N];
    logic [31:0] req_addr_i    [N];
    logic [N-1:0] req_wide_i, req_valid_i, req_ready_o;
    req_t        req_payload_o [N];
    logic [31:0] req_addr_o    [N];
    logic [N-1:0] req_wide_o, req_valid_o, req_ready_i;
    logic [31:0] rsp_payload_i [N];
    logic [31:0] rsp_addr_i    [N];
    logic [N-1:0] rsp_wide_i, rsp_valid_i, rsp_ready_o;
    logic [31:0] rsp_payload_o [N];
    logic [31:0] rsp_addr_o    [N];
    logic [N-1:0] rsp_wide_o, rsp_valid_o, rsp_ready_i;
    logic        busy_o;
    logic [0:0]  fifo_usage_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    tcdm_burst_sequencer #(
        .NrInOut      (N),
        .FifoDepth    (1),
        .MaxBlen      (16),
        .MetaIdWidth  (4),
        .TCDMAddrWidth(8),
        .req_payload_t(req_t),
        .rsp_payload_t(logic [31:0]),
        .addr_t       (logic [31:0])
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_payload_i(req_payload_i),
        .req_addr_i   (req_addr_i),
        .req_wide_i   (req_wide_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_payload_o(req_payload_o),
        .req_addr_o   (req_addr_o),
        .req_wide_o   (req_wide_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .rsp_payload_i(rsp_payload_i),
        .rsp_addr_i   (rsp_addr_i),
        .rsp_wide_i   (rsp_wide_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_ready_o  (rsp_ready_o),
        .rsp_payload_o(rsp_payload_o),
        .rsp_addr_o   (rsp_addr_o),
        .rsp_wide_o   (rsp_wide_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .busy_o       (busy_o),
        .fifo_usage_o (fifo_usage_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            req_payload_i[i] = '0;
            req_addr_i[i]    = '0;
            rsp_payload_i[i] = '0;
            rsp_addr_i[i]    = '0;
        end
        req_wide_i  = '0;
        req_valid_i = '0;
        req_ready_i = '1;
        rsp_wide_i  = '0;
        rsp_valid_i = '0;
        rsp_ready_i = '1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drive_burst(input int lane, input int blen, input int meta, input int tgt);
        req_payload_i[lane]                = '0;
        req_payload_i[lane].burst.isburst  = 1'b1;
        req_payload_i[lane].burst.blen     = 5'(blen);
        req_payload_i[lane].wdata.meta_id  = 4'(meta);
        req_payload_i[lane].wdata.data     = 16'(32'hA000 + lane);
        req_payload_i[lane].tgt_addr       = 8'(tgt);
        req_addr_i[lane]                   = 32'h1000_0000 + 32'(lane);
        req_wide_i[lane]                   = 1'b1;
        req_valid_i[lane]                  = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        req_payload_i[2].tgt_addr = 8'h5A;
        req_valid_i[2] = 1'b1;
        #2;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++;
        if (fifo_usage_o !== 1'b0) begin failures++; $display("FAIL reset_usage got=%0d exp=0", fifo_usage_o); end
        checks++;
        if (req_valid_o !== 4'b0100) begin failures++; $display("FAIL reset_bypass_valid got=%b exp=0100", req_valid_o); end
        checks++;
        if (req_payload_o[2].tgt_addr !== 8'h5A) begin failures++; $display("FAIL reset_bypass_tgt got=%h exp=5a", req_payload_o[2].tgt_addr); end
        apply_reset();
        $display("test_reset: done");
    endtask

    task automatic test_single_burst();
        apply_reset();
        drive_burst(1, 3, 5, 8);
        req_payload_i[0].tgt_addr = 8'h77;
        req_valid_i[0] = 1'b1;
        #2;
        checks++;
        if (req_ready_o[1] !== 1'b1) begin failures++; $display("FAIL single_push_ready got=%b exp=1", req_ready_o[1]); end
        checks++;
        if (req_valid_o !== 4'b0001) begin failures++; $display("FAIL single_push_valid got=%b exp=0001", req_valid_o); end
        step();
        req_valid_i[1] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b1111) begin failures++; $display("FAIL single_beat_valid got=%b exp=1111", req_valid_o); end
        checks++;
        if ({req_payload_o[1].wdata.meta_id, req_payload_o[2].wdata.meta_id, req_payload_o[3].wdata.meta_id} !== 12'h567) begin
            failures++; $display("FAIL single_meta got=%h exp=567",
                {req_payload_o[1].wdata.meta_id, req_payload_o[2].wdata.meta_id, req_payload_o[3].wdata.meta_id});
        end
        checks++;
        if ({req_payload_o[1].tgt_addr, req_payload_o[2].tgt_addr, req_payload_o[3].tgt_addr} !== 24'h08090A) begin
            failures++; $display("FAIL single_tgt got=%h exp=08090a",
                {req_payload_o[1].tgt_addr, req_payload_o[2].tgt_addr, req_payload_o[3].tgt_addr});
        end
        checks++;
        if (req_payload_o[0].tgt_addr !== 8'h77) begin failures++; $display("FAIL single_bypass_tgt got=%h exp=77", req_payload_o[0].tgt_addr); end
        checks++;
        if (req_addr_o[3] !== 32'h1000_0001 || req_wide_o[3] !== 1'b1 || req_payload_o[3].burst.isburst !== 1'b0) begin
            failures++; $display("FAIL single_carry addr=%h wide=%b isburst=%b exp=10000001/1/0",
                req_addr_o[3], req_wide_o[3], req_payload_o[3].burst.isburst);
        end
        step();
        #2;
        checks++;
        if (busy_o !== 1'b0 || req_valid_o !== 4'b0001) begin
            failures++; $display("FAIL single_end busy=%b valid=%b exp=0/0001", busy_o, req_valid_o);
        end
        $display("test_single_burst: done");
    endtask

    task automatic test_multi_beat();
        logic [7:0] exp_tgt [N];
        exp_tgt = '{8'h22, 8'h23, 8'h20, 8'h21};
        apply_reset();
        drive_burst(2, 6, 0, 8'h20);
        step();
        req_valid_i[2] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b1111) begin failures++; $display("FAIL multi_beat0_valid got=%b exp=1111", req_valid_o); end
        for (int l = 0; l < N; l++) begin
            checks++;
            if (req_payload_o[l].tgt_addr !== exp_tgt[l]) begin
                failures++; $display("FAIL multi_beat0_tgt lane=%0d got=%h exp=%h", l, req_payload_o[l].tgt_addr, exp_tgt[l]);
            end
        end
        step();
        #2;
        checks++;
        if (req_valid_o !== 4'b1100) begin failures++; $display("FAIL multi_beat1_valid got=%b exp=1100", req_valid_o); end
        checks++;
        if (req_payload_o[2].tgt_addr !== 8'h24 || req_payload_o[3].tgt_addr !== 8'h25) begin
            failures++; $display("FAIL multi_beat1_tgt got=%h,%h exp=24,25", req_payload_o[2].tgt_addr, req_payload_o[3].tgt_addr);
        end
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL multi_busy_beat1 got=%b exp=1", busy_o); end
        step();
        #2;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL multi_busy_end got=%b exp=0", busy_o); end
        $display("test_multi_beat: done");
    endtask

    task automatic test_bank_stall();
        apply_reset();
        drive_burst(0, 4, 1, 8'h60);
        req_ready_i[2] = 1'b0;
        step();
        req_valid_i[0] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b1111) begin failures++; $display("FAIL stall_first_valid got=%b exp=1111", req_valid_o); end
        for (int c = 0; c < 2; c++) begin
            step();
            #2;
            checks++;
            if (req_valid_o !== 4'b0100 || busy_o !== 1'b1) begin
                failures++; $display("FAIL stall_hold cycle=%0d valid=%b busy=%b exp=0100/1", c, req_valid_o, busy_o);
            end
        end
        step();
        req_ready_i[2] = 1'b1;
        #2;
        checks++;
        if (req_valid_o !== 4'b0100 || req_payload_o[2].tgt_addr !== 8'h62) begin
            failures++; $display("FAIL stall_release valid=%b tgt=%h exp=0100/62", req_valid_o, req_payload_o[2].tgt_addr);
        end
        step();
        #2;
        checks++;
        if (busy_o !== 1'b0 || req_valid_o !== 4'b0000) begin
            failures++; $display("FAIL stall_end busy=%b valid=%b exp=0/0000", busy_o, req_valid_o);
        end
        $display("test_bank_stall: done");
    endtask

    task automatic test_arbitration();
        apply_reset();
        drive_burst(0, 8, 0, 8'h10);
        drive_burst(3, 2, 0, 8'h30);
        #2;
        checks++;
        if (req_ready_o[0] !== 1'b1 || req_ready_o[3] !== 1'b0) begin
            failures++; $display("FAIL arb_first_ack got=%b exp=0001 on lanes 0/3", req_ready_o);
        end
        step();
        req_valid_i[0] = 1'b0;
        #2;
        checks++;
        if (req_ready_o[3] !== 1'b1 || req_payload_o[3].tgt_addr !== 8'h13) begin
            failures++; $display("FAIL arb_second_push ready3=%b tgt3=%h exp=1/13", req_ready_o[3], req_payload_o[3].tgt_addr);
        end
        step();
        req_valid_i[3] = 1'b0;
        drive_burst(1, 1, 0, 8'h50);
        #2;
        checks++;
        if (fifo_usage_o !== 1'b1 || req_ready_o[1] !== 1'b0 || req_payload_o[0].tgt_addr !== 8'h14) begin
            failures++; $display("FAIL arb_full usage=%0d ready1=%b tgt0=%h exp=1/0/14",
                fifo_usage_o, req_ready_o[1], req_payload_o[0].tgt_addr);
        end
        step();
        #2;
        checks++;
        if (req_ready_o[1] !== 1'b1 || fifo_usage_o !== 1'b1 || req_valid_o !== 4'b0000) begin
            failures++; $display("FAIL arb_push_pop ready1=%b usage=%0d valid=%b exp=1/1/0000",
                req_ready_o[1], fifo_usage_o, req_valid_o);
        end
        step();
        req_valid_i[1] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b1001 || req_payload_o[3].tgt_addr !== 8'h30 || req_payload_o[0].tgt_addr !== 8'h31) begin
            failures++; $display("FAIL arb_lane3_burst valid=%b tgt3=%h tgt0=%h exp=1001/30/31",
                req_valid_o, req_payload_o[3].tgt_addr, req_payload_o[0].tgt_addr);
        end
        step();
        step();
        #2;
        checks++;
        if (req_valid_o !== 4'b0010 || req_payload_o[1].tgt_addr !== 8'h50 || fifo_usage_o !== 1'b0) begin
            failures++; $display("FAIL arb_lane1_burst valid=%b tgt1=%h usage=%0d exp=0010/50/0",
                req_valid_o, req_payload_o[1].tgt_addr, fifo_usage_o);
        end
        step();
        #2;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL arb_end_busy got=%b exp=0", busy_o); end
        $display("test_arbitration: done");
    endtask

    task automatic test_rsp_stall();
        apply_reset();
        drive_burst(0, 4, 0, 8'h80);
        rsp_valid_i[1]   = 1'b1;
        rsp_ready_i[1]   = 1'b0;
        rsp_payload_i[1] = 32'hDEAD_BEEF;
        step();
        req_valid_i[0] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b1101) begin failures++; $display("FAIL rsp_stall_valid got=%b exp=1101", req_valid_o); end
        checks++;
        if (rsp_valid_o[1] !== 1'b1 || rsp_ready_o[1] !== 1'b0 || rsp_payload_o[1] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rsp_passthrough valid=%b ready=%b data=%h exp=1/0/deadbeef",
                rsp_valid_o[1], rsp_ready_o[1], rsp_payload_o[1]);
        end
        step();
        #2;
        checks++;
        if (req_valid_o !== 4'b0000 || busy_o !== 1'b1) begin
            failures++; $display("FAIL rsp_still_stalled valid=%b busy=%b exp=0000/1", req_valid_o, busy_o);
        end
        step();
        rsp_ready_i[1] = 1'b1;
        #2;
        checks++;
        if (req_valid_o !== 4'b0010 || req_payload_o[1].tgt_addr !== 8'h81) begin
            failures++; $display("FAIL rsp_released valid=%b tgt1=%h exp=0010/81", req_valid_o, req_payload_o[1].tgt_addr);
        end
        step();
        rsp_valid_i[1] = 1'b0;
        #2;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rsp_end_busy got=%b exp=0", busy_o); end
        $display("test_rsp_stall: done");
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive_burst(0, 12, 0, 8'hC0);
        step();
        req_valid_i[0] = 1'b0;
        step();
        step();
        #2;
        checks++;
        if (req_valid_o !== 4'b1111 || req_payload_o[0].tgt_addr !== 8'hC8) begin
            failures++; $display("FAIL midreset_beat2 valid=%b tgt0=%h exp=1111/c8", req_valid_o, req_payload_o[0].tgt_addr);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (req_valid_o !== 4'b0000 || busy_o !== 1'b0 || fifo_usage_o !== 1'b0) begin
            failures++; $display("FAIL midreset_state valid=%b busy=%b usage=%0d exp=0000/0/0",
                req_valid_o, busy_o, fifo_usage_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        drive_burst(1, 2, 2, 8'h40);
        step();
        req_valid_i[1] = 1'b0;
        #2;
        checks++;
        if (req_valid_o !== 4'b0110 || req_payload_o[1].tgt_addr !== 8'h40 || req_payload_o[2].tgt_addr !== 8'h41) begin
            failures++; $display("FAIL midreset_new_burst valid=%b tgt=%h,%h exp=0110/40,41",
                req_valid_o, req_payload_o[1].tgt_addr, req_payload_o[2].tgt_addr);
        end
        checks++;
        if (req_payload_o[2].wdata.meta_id !== 4'h3) begin
            failures++; $display("FAIL midreset_new_meta got=%h exp=3", req_payload_o[2].wdata.meta_id);
        end
        step();
        #2;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL midreset_end_busy got=%b exp=0", busy_o); end
        $display("test_reset_mid_burst: done");
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_beat();
        test_bank_stall();
        test_arbitration();
        test_rsp_stall();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
